// File: rtl/serial_logical_evaluator.sv
// serial_logical_evaluator
// Multi-cycle logical operator. Each operand is reduced to a boolean by
// OR-ing W bits per clock, LSB chunk first, over K = N/W scan cycles. The
// selected logical op is then applied to the two booleans. Operands enter
// and the result leaves over valid/ready handshakes. Latency does not
// depend on the data.
module serial_logical_evaluator #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         c
);

  localparam int K  = N / W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  // Operand widths must split into whole chunks.
  generate
    if (N < 1 || W < 1 || W > N || (N % W) != 0) begin : g_bad_param
      $error("serial_logical_evaluator: need 1 <= W <= N and N %% W == 0");
    end
  endgenerate

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, b_q;
  logic [1:0]      op_q;
  logic            acc_a_q, acc_b_q;
  logic [IW-1:0]   idx_q;
  logic            out_valid_q;
  logic            c_q;

  logic [W-1:0]    chunk_a, chunk_b;
  logic            last_scan;
  logic            fin_a, fin_b;
  logic            res;
  logic            accept;

  // The handshake is gated by in_ready, which is already low during reset.
  assign accept = in_valid && in_ready;

  // Select the chunk addressed by idx. A mux over constant slices keeps the
  // index arithmetic out of the part-select.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int k = 0; k < K; k++) begin
      if (idx_q == IW'(k)) begin
        chunk_a = a_q[k*W +: W];
        chunk_b = b_q[k*W +: W];
      end
    end
  end

  assign last_scan = (idx_q == IW'(K - 1));

  // The final accumulators include the chunk scanned on this edge.
  assign fin_a = acc_a_q | (|chunk_a);
  assign fin_b = acc_b_q | (|chunk_b);

  // Apply the captured op to the booleanized operands.
  always_comb begin
    res = 1'b0;
    case (op_q)
      OP_AND:  res = fin_a & fin_b;
      OP_OR:   res = fin_a | fin_b;
      OP_XOR:  res = fin_a ^ fin_b;
      OP_NAND: res = ~(fin_a & fin_b);
      default: res = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. DONE always has out_valid high, so out_ready alone
  // completes the output handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = SCAN;
      SCAN:    if (last_scan) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs. in_ready depends only on state and rst, so it never rises in
  // the same cycle as the output handshake.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = out_valid_q;
    c         = c_q;
  end

  // Datapath. Operands are captured on acceptance, and the scan accumulates
  // chunk ORs. The result and valid are registered at the final scan edge.
  // A reset mid-transaction drops everything, so no result is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      acc_a_q     <= 1'b0;
      acc_b_q     <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      c_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            acc_a_q <= 1'b0;
            acc_b_q <= 1'b0;
            idx_q   <= '0;
          end
        end
        SCAN: begin
          acc_a_q <= fin_a;
          acc_b_q <= fin_b;
          if (last_scan) begin
            c_q         <= res;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
